hash_pe_dispatcher: RTL
=======================

// Module: hash_pe_dispatcher
// PURPOSE
//  Scatter side of the post-hash reorder path: accepts one aligned row of HASH_ISSUE_WIDTH positions
//  (head address, per-position hash, literal data) and dispatches each position to the hash PE selected
//  by its hash low bits. PE collisions are serialized over several beats. Each beat carries at most one
//  job per PE and is shaped exactly as the reorder crossbar's input beat (mask/addr/delim/data).
// PARAMETERS
//  NUM_HASH_PE       `NUM_HASH_PE        number of hash PEs (power of 2, >=2)
//  HASH_ISSUE_WIDTH  `HASH_ISSUE_WIDTH   positions per row (power of 2, >=2)
//  ADDR_WIDTH        `ADDR_WIDTH         byte address width
//  HASH_BITS         `HASH_BITS          hash width per position; low log2(NUM_HASH_PE) bits = PE index
// PORTS
//  clk                 in   1                          clock
//  rst                 in   1                          async reset, active-high
//  input_valid         in   1                          row offered
//  input_head_addr     in   ADDR_WIDTH                 row base addr; low log2(HASH_ISSUE_WIDTH) bits are 0
//  input_row_valid     in   HASH_ISSUE_WIDTH           position j present
//  input_hash          in   HASH_ISSUE_WIDTH*HASH_BITS position j hash at [j*HASH_BITS +: HASH_BITS]
//  input_delim         in   1                          row ends a block
//  input_data          in   HASH_ISSUE_WIDTH*8         row literal bytes
//  input_ready         out  1                          row accepted when valid&&ready
//  output_valid        out  1                          beat valid
//  output_mask         out  NUM_HASH_PE                PE p gets a job this beat
//  output_addr         out  NUM_HASH_PE*ADDR_WIDTH     job addr = head_addr + j
//  output_hash         out  NUM_HASH_PE*HASH_BITS      job hash
//  output_delim        out  NUM_HASH_PE                delim, only on masked PEs of last beat
//  output_last         out  1                          last beat of current row
//  output_data         out  HASH_ISSUE_WIDTH*8         row data, repeated every beat of the row
//  output_ready        in   1                          beat consumed when valid&&ready
// BEHAVIOUR
//  - Reset: busy=0, pending=0, row regs=0; output_valid=0, output_mask=0, output_delim=0, output_last=0,
//    other outputs 0; input_ready=1 while rst deasserted after reset.
//  - State: IDLE (busy=0) / ISSUE (busy=1). Row regs + pending[HASH_ISSUE_WIDTH] are registered;
//    beat is combinational from them: output_valid = busy.
//  - Accept: input_ready = !busy || (output_valid && output_ready && output_last). On accept,
//    pending <= input_row_valid, busy <= (input_row_valid != 0). Latency: first beat cycle after accept.
//  - Per-PE select: cand_p = pending & {j : hash_j[PE bits]==p}; PE p takes lowest set j of cand_p.
//    output_mask[p] = |cand_p. Beat issued = OR of selected one-hots.
//  - output_last = (pending & ~issued) == 0. On fire: pending <= pending & ~issued; if last and no new
//    accept same cycle, busy <= 0. Back-to-back: last fire + accept same cycle -> no bubble.
//  - Beat count per row = max over PEs of popcount(cand_p); 1..HASH_ISSUE_WIDTH. No conflicts -> 1 row/cycle.
//  - output_addr lane p = head_addr | j (no carry since head aligned); unmasked lanes drive 0.
//  - output_delim[p] = row_delim & output_last & output_mask[p].
//  - Empty row (input_row_valid==0): consumed, no beat emitted; delim on empty row is a protocol
//    violation (sim assertion fires).
//  - Output stalled (valid&&!ready): all output bits held stable; pending unchanged.
//  - rst mid-row: pending row discarded, no partial beat survives.
// STRUCTURE
//  - parameters.vh: add NUM_HASH_PE_LOG2 (if absent), HASH_BITS; PE index slice macro.
//  - Sub-module: lowest_one_select #(W) (one-hot of lowest set bit), instanced per PE; reuse mux1h
//    for hash/offset lane selection.
//  - Optional forward_reg on the output when timing requires; adds 1 cycle, same handshake.
// TESTING (bench: NUM_HASH_PE=4, HASH_ISSUE_WIDTH=4, HASH_BITS=8)
//  1. head=0x100, row_valid=4'b1111, hashes PE 0,1,2,3 -> one beat, mask=4'b1111, addr 0x100..0x103, last=1.
//  2. hashes all PE 2, row_valid=1111 -> 4 beats, mask=0100 each, lane2 addr 0x100,0x101,0x102,0x103; last on 4th.
//  3. hashes PE 1,1,3,3, delim=1 -> beat1 mask=1010 addr 0x100/0x102 delim=0; beat2 mask=1010 delim=1010 last=1.
//  4. output_ready=0 for 5 cycles during case 3 -> beat1 held stable, no input accept, then resumes.
//  5. two conflict-free rows back-to-back, ready=1 -> beats on consecutive cycles, input_ready stays 1.
//  6. rst asserted after beat1 of case 2 -> output_valid=0 next cycle; new row issues cleanly after release.

Source files
------------

// File: rtl/hash_pe_dispatcher_pkg.sv
// Shared types and default sizing for the hash PE dispatcher.
//   state_e        : IDLE (no row held) / ISSUE (row held, beats being emitted)
//   DEF_*          : default parameter values used by the top module
package hash_pe_dispatcher_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam int DEF_NUM_HASH_PE      = 4;
  localparam int DEF_HASH_ISSUE_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH       = 16;
  localparam int DEF_HASH_BITS        = 8;

endpackage

// File: rtl/hash_pe_dispatcher_checker.sv
// Protocol checker for the hash PE dispatcher input side.
//   clk, rst          : clock and async active-high reset
//   input_valid/ready : row handshake
//   input_row_valid   : positions present in the offered row
//   input_delim       : block delimiter carried by the row
module hash_pe_dispatcher_checker #(
  parameter int HASH_ISSUE_WIDTH = 4
) (
  input logic                        clk,
  input logic                        rst,
  input logic                        input_valid,
  input logic                        input_ready,
  input logic [HASH_ISSUE_WIDTH-1:0] input_row_valid,
  input logic                        input_delim
);

  // An empty row emits no beat, so a delimiter on it would be silently lost.
  property p_no_delim_on_empty_row;
    @(posedge clk) disable iff (rst)
      (input_valid && input_ready && (input_row_valid == {HASH_ISSUE_WIDTH{1'b0}})) |-> !input_delim;
  endproperty

  a_no_delim_on_empty_row: assert property (p_no_delim_on_empty_row);

endmodule

// File: rtl/lowest_one_select.sv
// One-hot select of the lowest set bit of a request vector.
//   req : W-bit request vector
//   gnt : one-hot of the lowest set bit of req (all zero when req is zero)
module lowest_one_select #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  // Two's-complement trick: req & -req isolates the lowest set bit.
  assign gnt = req & (~req + {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hash_pe_dispatcher.sv
// Scatter stage of the post-hash reorder path. Accepts one aligned row of
// HASH_ISSUE_WIDTH positions and dispatches each position to the hash PE
// selected by the low bits of its hash, serializing PE collisions over beats.
// Ports:
//   clk, rst            : clock, async active-high reset
//   input_*             : row in (valid/ready, head addr, row_valid, hash, delim, data)
//   output_*            : beat out (valid/ready, mask, addr, hash, delim, last, data)
module hash_pe_dispatcher
  import hash_pe_dispatcher_pkg::*;
#(
  parameter int NUM_HASH_PE      = DEF_NUM_HASH_PE,
  parameter int HASH_ISSUE_WIDTH = DEF_HASH_ISSUE_WIDTH,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int HASH_BITS        = DEF_HASH_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  input_valid,
  input  logic [ADDR_WIDTH-1:0]                 input_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]           input_row_valid,
  input  logic [HASH_ISSUE_WIDTH*HASH_BITS-1:0] input_hash,
  input  logic                                  input_delim,
  input  logic [HASH_ISSUE_WIDTH*8-1:0]         input_data,
  output logic                                  input_ready,
  output logic                                  output_valid,
  output logic [NUM_HASH_PE-1:0]                output_mask,
  output logic [NUM_HASH_PE*ADDR_WIDTH-1:0]     output_addr,
  output logic [NUM_HASH_PE*HASH_BITS-1:0]      output_hash,
  output logic [NUM_HASH_PE-1:0]                output_delim,
  output logic                                  output_last,
  output logic [HASH_ISSUE_WIDTH*8-1:0]         output_data,
  input  logic                                  output_ready
);

  localparam int PE_BITS = $clog2(NUM_HASH_PE);
  localparam int IW      = HASH_ISSUE_WIDTH;
  localparam int HB      = HASH_BITS;

  state_e                 state_q, state_d;
  logic [IW-1:0]          pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]  head_q, head_d;
  logic [IW*HB-1:0]       hash_q, hash_d;
  logic                   delim_q, delim_d;
  logic [IW*8-1:0]        data_q, data_d;

  logic [IW-1:0]          cand_s [NUM_HASH_PE];
  logic [IW-1:0]          sel_s  [NUM_HASH_PE];
  logic [IW-1:0]          issued_s;
  logic                   busy_s;
  logic                   last_s;
  logic                   fire_s;
  logic                   accept_s;

  // Candidate matrix: pending positions whose hash maps to each PE.
  always_comb begin
    for (int p = 0; p < NUM_HASH_PE; p++) begin
      cand_s[p] = {IW{1'b0}};
      for (int j = 0; j < IW; j++) begin
        cand_s[p][j] = pending_q[j] && (hash_q[j*HB +: PE_BITS] == PE_BITS'(p));
      end
    end
  end

  for (genvar gp = 0; gp < NUM_HASH_PE; gp++) begin : g_pe_sel
    lowest_one_select #(.W(IW)) u_sel (
      .req (cand_s[gp]),
      .gnt (sel_s[gp])
    );
  end

  // Beat assembly: one-hot AND-OR lane muxes driven by each PE's selection.
  always_comb begin
    issued_s    = {IW{1'b0}};
    output_mask = {NUM_HASH_PE{1'b0}};
    output_addr = {(NUM_HASH_PE*ADDR_WIDTH){1'b0}};
    output_hash = {(NUM_HASH_PE*HB){1'b0}};
    for (int p = 0; p < NUM_HASH_PE; p++) begin
      output_mask[p] = |cand_s[p];
      issued_s       = issued_s | sel_s[p];
      for (int j = 0; j < IW; j++) begin
        // Head is row-aligned, so OR-ing the offset is the same as adding it.
        output_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = output_addr[p*ADDR_WIDTH +: ADDR_WIDTH]
            | ({ADDR_WIDTH{sel_s[p][j]}} & (head_q | ADDR_WIDTH'(j)));
        output_hash[p*HB +: HB] = output_hash[p*HB +: HB]
            | ({HB{sel_s[p][j]}} & hash_q[j*HB +: HB]);
      end
    end
  end

  assign busy_s       = (state_q == ST_ISSUE);
  // Gated by busy so an idle dispatcher never advertises a last beat.
  assign last_s       = busy_s && ((pending_q & ~issued_s) == {IW{1'b0}});
  assign output_valid = busy_s;
  assign output_last  = last_s;
  assign output_delim = {NUM_HASH_PE{delim_q & last_s}} & output_mask;
  assign output_data  = data_q;
  assign fire_s       = busy_s && output_ready;
  // Accepting alongside the final beat keeps conflict-free rows at one per cycle.
  assign input_ready  = !busy_s || (fire_s && last_s);
  assign accept_s     = input_valid && input_ready;

  // Next-state: load a new row on accept, retire issued positions on fire.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    head_d    = head_q;
    hash_d    = hash_q;
    delim_d   = delim_q;
    data_d    = data_q;
    if (accept_s) begin
      pending_d = input_row_valid;
      head_d    = input_head_addr;
      hash_d    = input_hash;
      delim_d   = input_delim;
      data_d    = input_data;
      // Empty rows are consumed without producing a beat.
      state_d   = (input_row_valid != {IW{1'b0}}) ? ST_ISSUE : ST_IDLE;
    end else if (fire_s) begin
      pending_d = pending_q & ~issued_s;
      state_d   = last_s ? ST_IDLE : ST_ISSUE;
    end else begin
      state_d   = state_q;
    end
  end

  // State and row registers; reset discards any partially issued row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= {IW{1'b0}};
      head_q    <= {ADDR_WIDTH{1'b0}};
      hash_q    <= {(IW*HB){1'b0}};
      delim_q   <= 1'b0;
      data_q    <= {(IW*8){1'b0}};
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      head_q    <= head_d;
      hash_q    <= hash_d;
      delim_q   <= delim_d;
      data_q    <= data_d;
    end
  end

endmodule
